// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage: RV32 loads/stores over a req/ack bus, registered write-back slot
module mem_access_stage #(
    parameter int TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic        exeValid,
    input  logic [31:0] exeResult,
    input  logic [31:0] exeRs2,
    input  logic [4:0]  exeRd,
    input  logic        exeWmem,
    input  logic        exeRmem,
    input  logic        exeWreg,
    input  logic [2:0]  exeFunc3,
    output logic        stall,
    output logic        memValid,
    output logic [4:0]  memRd,
    output logic [31:0] memResult,
    output logic        memWreg,
    output logic        memRmem,
    output logic        excMisal,
    output logic        excBus,
    output logic        busReq,
    output logic        busWe,
    output logic [31:0] busAddr,
    output logic [31:0] busWdata,
    output logic [3:0]  busBe,
    input  logic        busAck,
    input  logic [31:0] busRdata
);

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic {IDLE, BUS} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;

    logic [29:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_be;
    logic        lat_we;

    logic        is_access, f3_ok, aligned, acc_ok;
    logic [3:0]  req_be;
    logic [31:0] req_wdata, rsh, load_data;

    logic        cur_req, cur_we, stall_c;
    logic [31:0] cur_addr, cur_wdata;
    logic [3:0]  cur_be;

    logic        o_valid, o_wreg, o_rmem, o_misal, o_bus;
    logic [4:0]  o_rd;
    logic [31:0] o_result;

    assign is_access = exeWmem | exeRmem;
    assign acc_ok    = f3_ok & aligned;

    always_comb begin
        f3_ok = 1'b0;
        if (exeRmem && !exeWmem)
            f3_ok = exeFunc3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        else if (exeWmem && !exeRmem)
            f3_ok = exeFunc3 inside {3'b000, 3'b001, 3'b010};
    end

    always_comb begin
        aligned   = 1'b1;
        req_be    = 4'b1111;
        req_wdata = exeRs2;
        case (exeFunc3[1:0])
            2'b00: begin
                req_be    = 4'b0001 << exeResult[1:0];
                req_wdata = {4{exeRs2[7:0]}};
            end
            2'b01: begin
                aligned   = ~exeResult[0];
                req_be    = 4'b0011 << exeResult[1:0];
                req_wdata = {2{exeRs2[15:0]}};
            end
            2'b10: aligned = (exeResult[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
    end

    // Exe inputs are held by stall, so the live address/func3 select the load lane
    always_comb begin
        rsh = busRdata >> {exeResult[1:0], 3'b000};
        case (exeFunc3)
            3'b000:  load_data = {{24{rsh[7]}}, rsh[7:0]};
            3'b001:  load_data = {{16{rsh[15]}}, rsh[15:0]};
            3'b100:  load_data = {24'd0, rsh[7:0]};
            3'b101:  load_data = {16'd0, rsh[15:0]};
            default: load_data = busRdata;
        endcase
    end

    always_comb begin
        state_nx  = state;
        cur_req   = 1'b0;
        cur_we    = 1'b0;
        cur_addr  = 32'd0;
        cur_wdata = 32'd0;
        cur_be    = 4'd0;
        stall_c   = 1'b0;
        o_valid   = 1'b0;
        o_rd      = 5'd0;
        o_result  = 32'd0;
        o_wreg    = 1'b0;
        o_rmem    = 1'b0;
        o_misal   = 1'b0;
        o_bus     = 1'b0;
        case (state)
            IDLE: begin
                if (exeValid) begin
                    if (!is_access) begin
                        o_valid  = 1'b1;
                        o_rd     = exeRd;
                        o_result = exeResult;
                        o_wreg   = exeWreg;
                    end else if (!acc_ok) begin
                        o_valid = 1'b1;
                        o_rd    = exeRd;
                        o_rmem  = exeRmem;
                        o_misal = 1'b1;
                    end else begin
                        cur_req   = 1'b1;
                        cur_we    = exeWmem;
                        cur_addr  = {exeResult[31:2], 2'b00};
                        cur_wdata = req_wdata;
                        cur_be    = req_be;
                        if (busAck) begin
                            o_valid  = 1'b1;
                            o_rd     = exeRd;
                            o_result = exeRmem ? load_data : exeResult;
                            o_wreg   = exeWreg;
                            o_rmem   = exeRmem;
                        end else begin
                            stall_c  = 1'b1;
                            state_nx = BUS;
                        end
                    end
                end
            end
            BUS: begin
                cur_req   = 1'b1;
                cur_we    = lat_we;
                cur_addr  = {lat_addr, 2'b00};
                cur_wdata = lat_wdata;
                cur_be    = lat_be;
                o_rd      = exeRd;
                o_rmem    = exeRmem;
                if (busAck) begin
                    o_valid  = 1'b1;
                    o_result = exeRmem ? load_data : exeResult;
                    o_wreg   = exeWreg;
                    state_nx = IDLE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    o_valid  = 1'b1;
                    o_bus    = 1'b1;
                    state_nx = IDLE;
                end else begin
                    stall_c = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Reset forces the combinational bus/stall outputs low without waiting for a clock
    assign busReq   = nRST & cur_req;
    assign busWe    = nRST & cur_we;
    assign busAddr  = nRST ? cur_addr  : 32'd0;
    assign busWdata = nRST ? cur_wdata : 32'd0;
    assign busBe    = nRST ? cur_be    : 4'd0;
    assign stall    = nRST & stall_c;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            lat_we    <= 1'b0;
            memValid  <= 1'b0;
            memRd     <= '0;
            memResult <= '0;
            memWreg   <= 1'b0;
            memRmem   <= 1'b0;
            excMisal  <= 1'b0;
            excBus    <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == BUS && state_nx == BUS)
                cnt <= cnt + CW'(1);
            else
                cnt <= '0;
            if (state == IDLE && state_nx == BUS) begin
                lat_addr  <= cur_addr[31:2];
                lat_wdata <= cur_wdata;
                lat_be    <= cur_be;
                lat_we    <= cur_we;
            end
            memValid  <= o_valid;
            memRd     <= o_rd;
            memResult <= o_result;
            memWreg   <= o_wreg;
            memRmem   <= o_rmem;
            excMisal  <= o_misal;
            excBus    <= o_bus;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage
module tb_mem_access_stage;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        nRST;
    logic        exeValid, exeWmem, exeRmem, exeWreg;
    logic [31:0] exeResult, exeRs2;
    logic [4:0]  exeRd;
    logic [2:0]  exeFunc3;
    logic        stall, memValid, memWreg, memRmem, excMisal, excBus;
    logic [4:0]  memRd;
    logic [31:0] memResult;
    logic        busReq, busWe, busAck;
    logic [31:0] busAddr, busWdata, busRdata;
    logic [3:0]  busBe;

    int n_cmp = 0;
    int n_err = 0;

    int          st, rq;
    logic [3:0]  be0;
    logic [31:0] wd0, ad0;
    logic        we0;

    mem_access_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .nRST(nRST),
        .exeValid(exeValid), .exeResult(exeResult), .exeRs2(exeRs2), .exeRd(exeRd),
        .exeWmem(exeWmem), .exeRmem(exeRmem), .exeWreg(exeWreg), .exeFunc3(exeFunc3),
        .stall(stall), .memValid(memValid), .memRd(memRd), .memResult(memResult),
        .memWreg(memWreg), .memRmem(memRmem), .excMisal(excMisal), .excBus(excBus),
        .busReq(busReq), .busWe(busWe), .busAddr(busAddr), .busWdata(busWdata),
        .busBe(busBe), .busAck(busAck), .busRdata(busRdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_exe(input logic v, input logic [31:0] res, input logic [31:0] rs2,
                           input logic [4:0] rd, input logic wm, input logic rm,
                           input logic wr, input logic [2:0] f3);
        exeValid = v; exeResult = res; exeRs2 = rs2; exeRd = rd;
        exeWmem = wm; exeRmem = rm; exeWreg = wr; exeFunc3 = f3;
    endtask

    // Called at a negedge with exe inputs applied; returns at the negedge after the slot retires
    task automatic run_bus(input int ack_at, input logic [31:0] rdata,
                           output int stalls, output int reqs, output logic [3:0] b0,
                           output logic [31:0] w0, output logic [31:0] a0, output logic e0);
        logic done;
        done = 1'b0; stalls = 0; reqs = 0;
        b0 = '0; w0 = '0; a0 = '0; e0 = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            busAck   = (i == ack_at);
            busRdata = rdata;
            #2;
            if (i == 0) begin
                b0 = busBe; w0 = busWdata; a0 = busAddr; e0 = busWe;
            end
            if (busReq) reqs++;
            if (stall) stalls++;
            else done = 1'b1;
            @(negedge clk);
        end
        busAck = 1'b0;
        chk("bus_bound", 32'(done), 32'd1);
        set_exe(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic load_case(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                             input logic [31:0] rdata, input logic [3:0] exp_be,
                             input logic [31:0] exp_res);
        set_exe(1'b1, addr, 32'd0, 5'd9, 1'b0, 1'b1, 1'b1, f3);
        run_bus(1, rdata, st, rq, be0, wd0, ad0, we0);
        chk({tag, "_be"}, 32'(be0), 32'(exp_be));
        chk({tag, "_res"}, memResult, exp_res);
        chk({tag, "_valid"}, 32'(memValid), 32'd1);
        chk({tag, "_stalls"}, 32'(st), 32'd1);
    endtask

    initial begin
        nRST = 1'b0; busAck = 1'b0; busRdata = 32'd0;
        // Legal load presented during reset must not reach the bus
        set_exe(1'b1, 32'h200, 32'd0, 5'd1, 1'b0, 1'b1, 1'b1, 3'b010);
        repeat (2) @(negedge clk);
        #2;
        chk("rst_busReq", 32'(busReq), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_memValid", 32'(memValid), 32'd0);
        chk("rst_memResult", memResult, 32'd0);
        chk("rst_busAddr", busAddr, 32'd0);
        @(negedge clk);
        set_exe(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0);
        nRST = 1'b1;
        @(negedge clk);

        // ALU pass-through
        set_exe(1'b1, 32'h1234, 32'd0, 5'd5, 1'b0, 1'b0, 1'b1, 3'd0);
        run_bus(-1, 32'd0, st, rq, be0, wd0, ad0, we0);
        chk("alu_stalls", 32'(st), 32'd0);
        chk("alu_reqs", 32'(rq), 32'd0);
        chk("alu_res", memResult, 32'h1234);
        chk("alu_wreg", 32'(memWreg), 32'd1);
        chk("alu_rd", 32'(memRd), 32'd5);
        @(negedge clk);
        chk("idle_valid", 32'(memValid), 32'd0);

        // SB to byte lane 3, ack on the fourth request cycle
        set_exe(1'b1, 32'h103, 32'hAABBCCDD, 5'd0, 1'b1, 1'b0, 1'b0, 3'b000);
        run_bus(3, 32'd0, st, rq, be0, wd0, ad0, we0);
        chk("sb_be", 32'(be0), 32'h8);
        chk("sb_wdata", wd0, 32'hDDDDDDDD);
        chk("sb_addr", ad0, 32'h100);
        chk("sb_we", 32'(we0), 32'd1);
        chk("sb_stalls", 32'(st), 32'd3);
        chk("sb_reqs", 32'(rq), 32'd4);
        chk("sb_valid", 32'(memValid), 32'd1);
        chk("sb_wreg", 32'(memWreg), 32'd0);

        // SH upper half
        set_exe(1'b1, 32'h102, 32'h12345678, 5'd0, 1'b1, 1'b0, 1'b0, 3'b001);
        run_bus(1, 32'd0, st, rq, be0, wd0, ad0, we0);
        chk("sh_be", 32'(be0), 32'hC);
        chk("sh_wdata", wd0, 32'h56785678);

        load_case("lb", 32'h102, 3'b000, 32'h00800000, 4'b0100, 32'hFFFFFF80);
        load_case("lbu", 32'h102, 3'b100, 32'h00800000, 4'b0100, 32'h00000080);
        load_case("lh", 32'h102, 3'b001, 32'h80010000, 4'b1100, 32'hFFFF8001);
        load_case("lhu", 32'h100, 3'b101, 32'h1234ABCD, 4'b0011, 32'h0000ABCD);
        chk("lhu_rmem", 32'(memRmem), 32'd1);

        // LW acked in the request cycle: no stall at all
        set_exe(1'b1, 32'h104, 32'd0, 5'd3, 1'b0, 1'b1, 1'b1, 3'b010);
        run_bus(0, 32'hDEADBEEF, st, rq, be0, wd0, ad0, we0);
        chk("lw0_stalls", 32'(st), 32'd0);
        chk("lw0_res", memResult, 32'hDEADBEEF);

        // Misaligned LW, illegal func3, and Wmem&Rmem are all dropped with excMisal
        set_exe(1'b1, 32'h106, 32'd0, 5'd4, 1'b0, 1'b1, 1'b1, 3'b010);
        run_bus(-1, 32'd0, st, rq, be0, wd0, ad0, we0);
        chk("mis_reqs", 32'(rq), 32'd0);
        chk("mis_exc", 32'(excMisal), 32'd1);
        chk("mis_valid", 32'(memValid), 32'd1);
        chk("mis_wreg", 32'(memWreg), 32'd0);
        @(negedge clk);
        chk("mis_pulse", 32'(excMisal), 32'd0);
        set_exe(1'b1, 32'h100, 32'd0, 5'd4, 1'b0, 1'b1, 1'b1, 3'b011);
        run_bus(-1, 32'd0, st, rq, be0, wd0, ad0, we0);
        chk("f3_exc", 32'(excMisal), 32'd1);
        set_exe(1'b1, 32'h100, 32'd0, 5'd4, 1'b1, 1'b1, 1'b1, 3'b010);
        run_bus(-1, 32'd0, st, rq, be0, wd0, ad0, we0);
        chk("wr_exc", 32'(excMisal), 32'd1);
        chk("wr_reqs", 32'(rq), 32'd0);

        // LH timeout: one IDLE request cycle plus TO bus cycles, last one unstalled
        set_exe(1'b1, 32'h100, 32'd0, 5'd6, 1'b0, 1'b1, 1'b1, 3'b001);
        run_bus(-1, 32'd0, st, rq, be0, wd0, ad0, we0);
        chk("to_stalls", 32'(st), 32'(TO));
        chk("to_reqs", 32'(rq), 32'(TO + 1));
        chk("to_excbus", 32'(excBus), 32'd1);
        chk("to_valid", 32'(memValid), 32'd1);
        chk("to_wreg", 32'(memWreg), 32'd0);
        #2;
        chk("to_req_drop", 32'(busReq), 32'd0);
        @(negedge clk);
        chk("to_pulse", 32'(excBus), 32'd0);

        // Ack on the timeout cycle completes the access
        set_exe(1'b1, 32'h100, 32'd0, 5'd6, 1'b0, 1'b1, 1'b1, 3'b101);
        run_bus(TO, 32'h0000BEEF, st, rq, be0, wd0, ad0, we0);
        chk("tack_excbus", 32'(excBus), 32'd0);
        chk("tack_res", memResult, 32'h0000BEEF);
        chk("tack_wreg", 32'(memWreg), 32'd1);

        // Reset in the middle of an access
        set_exe(1'b1, 32'h200, 32'd0, 5'd7, 1'b0, 1'b1, 1'b1, 3'b010);
        @(negedge clk);
        #2;
        chk("mid_req", 32'(busReq), 32'd1);
        nRST = 1'b0;
        #1;
        chk("mid_req_rst", 32'(busReq), 32'd0);
        chk("mid_stall_rst", 32'(stall), 32'd0);
        chk("mid_valid_rst", 32'(memValid), 32'd0);
        @(negedge clk);
        set_exe(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0);
        nRST = 1'b1;
        busAck = 1'b1; busRdata = 32'h11111111;
        @(negedge clk);
        busAck = 1'b0;
        chk("late_ack_valid", 32'(memValid), 32'd0);
        set_exe(1'b1, 32'hCAFE, 32'd0, 5'd2, 1'b0, 1'b0, 1'b1, 3'd0);
        run_bus(-1, 32'd0, st, rq, be0, wd0, ad0, we0);
        chk("post_rst_res", memResult, 32'hCAFE);
        chk("post_rst_stalls", 32'(st), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
